// File: rtl/fabric_config_loader.sv
// fabric_config_loader: streams host words LSB-first into the fabric config chain and commits with a set pulse; FABRIC_CFG_READBACK_EN adds chain readback
module fabric_config_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_shift,
    output logic              cfg_cen,
    output logic              cfg_set,
    input  logic              cfg_shift_back,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] rb_word,
    output logic              rb_valid
);
    localparam int WL_W = $clog2(WORD_W + 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_SET   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WL_W-1:0]   word_left_q, word_left_d;
    logic [31:0]       remain;
    logic              last_bit, word_end;

    assign remain   = 32'(CHAIN_LEN) - 32'(bit_cnt_q);
    assign last_bit = 32'(bit_cnt_q) + 32'd1 == 32'(CHAIN_LEN);
    assign word_end = last_bit || word_left_q == WL_W'(1);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        word_left_d = word_left_q;
        case (state_q)
            S_IDLE: begin
                state_d   = start ? S_LOAD : S_IDLE;
                bit_cnt_d = start ? '0 : bit_cnt_q;
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (word_valid) begin
                    state_d     = S_SHIFT;
                    sr_d        = word_in;
                    word_left_d = WL_W'(remain >= 32'(WORD_W) ? 32'(WORD_W) : remain);
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    sr_d        = sr_q >> 1;
                    bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                    word_left_d = word_left_q - WL_W'(1);
                    // chain completion outranks word exhaustion
                    state_d     = last_bit ? S_SET : (word_end ? S_LOAD : S_SHIFT);
                end
            end
            S_SET:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            word_left_q <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            word_left_q <= word_left_d;
        end
    end

    assign word_ready = state_q == S_LOAD;
    assign cfg_cen    = state_q == S_SHIFT;
    assign cfg_shift  = cfg_cen & sr_q[0];
    assign cfg_set    = state_q == S_SET;
    assign done       = state_q == S_DONE;
    assign busy       = state_q != S_IDLE;

`ifdef FABRIC_CFG_READBACK_EN
    localparam int IX_W = $clog2(WORD_W);

    logic [WORD_W-1:0] rb_acc_q, rb_acc_d, rb_word_q, rb_word_d;
    logic              rb_valid_q, rb_valid_d;
    logic [IX_W-1:0]   rb_idx;

    // words start on WORD_W-aligned chain positions, so the bit offset gives the slot
    assign rb_idx = IX_W'(32'(bit_cnt_q) % WORD_W);

    always_comb begin
        rb_acc_d = state_q == S_LOAD ? '0 : rb_acc_q;
        if (state_q == S_SHIFT) rb_acc_d[rb_idx] = cfg_shift_back;
        rb_valid_d = state_q == S_SHIFT && !abort && word_end;
        rb_word_d  = rb_valid_d ? rb_acc_d : rb_word_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rb_acc_q   <= '0;
            rb_word_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_acc_q   <= rb_acc_d;
            rb_word_q  <= rb_word_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign rb_word  = rb_word_q;
    assign rb_valid = rb_valid_q;
`else
    logic unused_shift_back;
    assign unused_shift_back = cfg_shift_back;
    assign rb_word  = '0;
    assign rb_valid = 1'b0;
`endif
endmodule

// File: tb/tb_fabric_config_loader.sv
// tb_fabric_config_loader: directed bench for fabric_config_loader driving a 40-bit chain model
module tb_fabric_config_loader;
    logic        clk = 1'b0;
    logic        rst, start, abort, word_valid, word_ready;
    logic        cfg_shift, cfg_cen, cfg_set, cfg_shift_back, busy, done, rb_valid;
    logic [15:0] word_in, rb_word;
    logic [39:0] chain = '0;
    logic [39:0] preload_val;
    logic        preload_en;
    logic [15:0] rb_log [0:7];

    int cyc = 0, cen_cnt = 0, set_cnt = 0, done_cnt = 0, hs_cnt = 0, rdy_cnt = 0, rb_n = 0;
    int last_cen = 0, set_at = 0, done_at = 0, start_at = 0;
    int tests = 0, fails = 0;
    int b_cen, b_set, b_done, b_hs, b_rdy, b_rb;

    fabric_config_loader #(.WORD_W(16), .CHAIN_LEN(40)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
        .cfg_shift(cfg_shift), .cfg_cen(cfg_cen), .cfg_set(cfg_set),
        .cfg_shift_back(cfg_shift_back), .busy(busy), .done(done),
        .rb_word(rb_word), .rb_valid(rb_valid)
    );

    always #5 clk = ~clk;

    // chain model: new bit enters at the head (bit 39), tail bit 0 exits
    assign cfg_shift_back = chain[0];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload_en) chain <= preload_val;
        else if (cfg_cen) chain <= {cfg_shift, chain[39:1]};
        if (cfg_cen) begin cen_cnt <= cen_cnt + 1; last_cen <= cyc; end
        if (cfg_set) begin set_cnt <= set_cnt + 1; set_at <= cyc; end
        if (done) begin done_cnt <= done_cnt + 1; done_at <= cyc; end
        if (start && !busy && rst) start_at <= cyc;
        if (word_valid && word_ready) hs_cnt <= hs_cnt + 1;
        if (word_ready) rdy_cnt <= rdy_cnt + 1;
        if (rb_valid) begin rb_log[rb_n % 8] <= rb_word; rb_n <= rb_n + 1; end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_cen = cen_cnt; b_set = set_cnt; b_done = done_cnt;
        b_hs = hs_cnt; b_rdy = rdy_cnt; b_rb = rb_n;
    endtask

    task automatic feed(input logic [15:0] w, input int stall);
        int n = 0;
        while (!word_ready && n < 200) begin @(negedge clk); n++; end
        check("ready_seen", 64'(word_ready), 64'd1);
        repeat (stall) @(negedge clk);
        word_in = w;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
    endtask

    task automatic kick(input logic with_abort);
        start = 1'b1;
        abort = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("load_after_start", 64'(word_ready), 64'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin @(negedge clk); n++; end
        check("done_seen", 64'(done), 64'd1);
        @(negedge clk);
        check("idle_after_done", 64'(busy), 64'd0);
    endtask

    task automatic do_load(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                           input int stall, input logic with_abort);
        kick(with_abort);
        feed(a, 0);
        feed(b, stall);
        feed(c, 0);
        wait_done();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; word_in = '0; word_valid = 1'b0;
        preload_en = 1'b0; preload_val = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({word_ready, cfg_shift, cfg_cen, cfg_set, busy, done, rb_valid, rb_word}), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        snap();
        do_load(16'hA5A5, 16'h0F0F, 16'h00C3, 0, 1'b0);
        check("full_chain", 64'(chain), 64'hC3_0F0F_A5A5);
        check("full_cen", 64'(cen_cnt - b_cen), 64'd40);
        check("full_set", 64'(set_cnt - b_set), 64'd1);
        check("full_done", 64'(done_cnt - b_done), 64'd1);
        check("full_hs", 64'(hs_cnt - b_hs), 64'd3);
        check("full_rdy", 64'(rdy_cnt - b_rdy), 64'd3);
        check("full_latency", 64'(done_at - start_at), 64'd45);
        check("set_after_last", 64'(set_at - last_cen), 64'd1);
        check("done_after_last", 64'(done_at - last_cen), 64'd2);

        snap();
        do_load(16'hA5A5, 16'h0F0F, 16'hFFC3, 0, 1'b0);
        check("partial_chain", 64'(chain), 64'hC3_0F0F_A5A5);
        check("partial_cen", 64'(cen_cnt - b_cen), 64'd40);
        check("partial_hs", 64'(hs_cnt - b_hs), 64'd3);
        check("partial_rdy", 64'(rdy_cnt - b_rdy), 64'd3);

        snap();
        do_load(16'h1234, 16'hBEEF, 16'h0077, 5, 1'b0);
        check("stall_chain", 64'(chain), 64'h77_BEEF_1234);
        check("stall_cen", 64'(cen_cnt - b_cen), 64'd40);
        check("stall_latency", 64'(done_at - start_at), 64'd50);
        check("stall_rdy", 64'(rdy_cnt - b_rdy), 64'd8);

        snap();
        begin
            int n = 0;
            kick(1'b0);
            feed(16'hA5A5, 0);
            feed(16'h0F0F, 0);
            while (cen_cnt - b_cen < 20 && n < 200) begin @(negedge clk); n++; end
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("abort_busy", 64'(busy), 64'd0);
            check("abort_ready", 64'(word_ready), 64'd0);
            repeat (3) @(negedge clk);
            check("abort_no_set", 64'(set_cnt - b_set), 64'd0);
            check("abort_no_done", 64'(done_cnt - b_done), 64'd0);
            check("abort_cen", 64'(cen_cnt - b_cen), 64'd21);
        end
        snap();
        do_load(16'hA5A5, 16'h0F0F, 16'h00C3, 0, 1'b1);
        check("reload_chain", 64'(chain), 64'hC3_0F0F_A5A5);
        check("reload_done", 64'(done_cnt - b_done), 64'd1);

        kick(1'b0);
        feed(16'h5555, 0);
        repeat (4) @(negedge clk);
        check("pre_reset_shift", 64'(cfg_cen), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_outputs", 64'({word_ready, cfg_shift, cfg_cen, cfg_set, busy, done, rb_valid, rb_word}), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        snap();
        kick(1'b0);
        feed(16'hCAFE, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed(16'hF00D, 0);
        feed(16'h0042, 0);
        wait_done();
        check("busy_start_chain", 64'(chain), 64'h42_F00D_CAFE);
        check("busy_start_latency", 64'(done_at - start_at), 64'd45);
        check("busy_start_done", 64'(done_cnt - b_done), 64'd1);
        check("busy_start_cen", 64'(cen_cnt - b_cen), 64'd40);

        preload_val = 40'h12_3456_789A;
        preload_en = 1'b1;
        @(negedge clk);
        preload_en = 1'b0;
        snap();
        do_load(16'hA5A5, 16'h0F0F, 16'h00C3, 0, 1'b0);
        check("rb_load_chain", 64'(chain), 64'hC3_0F0F_A5A5);
`ifdef FABRIC_CFG_READBACK_EN
        check("rb_strobes", 64'(rb_n - b_rb), 64'd3);
        check("rb_word0", 64'(rb_log[b_rb % 8]), 64'h789A);
        check("rb_word1", 64'(rb_log[(b_rb + 1) % 8]), 64'h3456);
        check("rb_word2", 64'(rb_log[(b_rb + 2) % 8]), 64'h0012);
`else
        check("rb_strobes", 64'(rb_n - b_rb), 64'd0);
        check("rb_word_tied", 64'(rb_word), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
